// File: rtl/playback_pkg.sv
// rtl/playback_pkg.sv - shared types and note-to-half-period table for note playback
// Contents: state_e (sequencer FSM states), HALF_W (half-period width) and
// HALF_TABLE (half-period in samples at 48 kHz, indexed by note code; code 0 is a rest).
package playback_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_DONE
    } state_e;

    localparam int HALF_W = 16;

    // half = round(48000 / (2 * 440 * 2^((n-49)/12))); code 49 is A4.
    localparam logic [HALF_W-1:0] HALF_TABLE [64] = '{
        16'd0,   16'd873, 16'd824, 16'd778, 16'd734, 16'd693, 16'd654, 16'd617,
        16'd582, 16'd550, 16'd519, 16'd490, 16'd462, 16'd436, 16'd412, 16'd389,
        16'd367, 16'd346, 16'd327, 16'd309, 16'd291, 16'd275, 16'd259, 16'd245,
        16'd231, 16'd218, 16'd206, 16'd194, 16'd183, 16'd173, 16'd163, 16'd154,
        16'd146, 16'd137, 16'd130, 16'd122, 16'd116, 16'd109, 16'd103, 16'd97,
        16'd92,  16'd87,  16'd82,  16'd77,  16'd73,  16'd69,  16'd65,  16'd61,
        16'd58,  16'd55,  16'd51,  16'd49,  16'd46,  16'd43,  16'd41,  16'd39,
        16'd36,  16'd34,  16'd32,  16'd31,  16'd29,  16'd27,  16'd26,  16'd24
    };

endpackage

// File: rtl/note_period_rom.sv
// rtl/note_period_rom.sv - combinational note code to square-wave half-period lookup
// Ports: note_i (note code), half_o (half-period in samples, 0 for rest).
module note_period_rom
    import playback_pkg::*;
#(
    parameter int NOTE_W = 6
) (
    input  logic [NOTE_W-1:0] note_i,
    output logic [HALF_W-1:0] half_o
);

    assign half_o = HALF_TABLE[note_i];

endmodule

// File: rtl/poly_note_playback.sv
// rtl/poly_note_playback.sv - multi-voice square-wave note sequencer driving the codec write port
// Ports: clk/reset_n (async active-low), write_en (play level), loop_en (wrap after last note),
// note_count (valid slots per voice), note_mem (packed per-voice note tables),
// write_ready/write/write_data (codec sample handshake), busy/done (status), note_idx (current slot).
module poly_note_playback
    import playback_pkg::*;
#(
    parameter  int VOICES           = 2,
    parameter  int DEPTH            = 40,
    parameter  int NOTE_W           = 6,
    parameter  int SAMPLE_W         = 24,
    parameter  int SAMPLES_PER_NOTE = 12000,
    parameter  int AMPLITUDE        = 1 << 20,
    localparam int CNT_W            = $clog2(DEPTH + 1),
    localparam int IDX_W            = $clog2(DEPTH)
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            write_en,
    input  logic                            loop_en,
    input  logic [CNT_W-1:0]                note_count,
    input  logic [VOICES*DEPTH*NOTE_W-1:0]  note_mem,
    input  logic                            write_ready,
    output logic                            write,
    output logic [SAMPLE_W-1:0]             write_data,
    output logic                            busy,
    output logic                            done,
    output logic [IDX_W-1:0]                note_idx
);

    localparam int SC_W  = $clog2(SAMPLES_PER_NOTE + 1);
    localparam int MIX_W = SAMPLE_W + 2;
    localparam logic [SC_W-1:0]          SC_LAST = SC_W'(SAMPLES_PER_NOTE - 1);
    localparam logic signed [MIX_W-1:0]  AMP_POS = MIX_W'(AMPLITUDE);
    localparam logic signed [MIX_W-1:0]  AMP_NEG = MIX_W'(-AMPLITUDE);
    localparam logic signed [MIX_W-1:0]  SAT_MAX = {{3{1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [MIX_W-1:0]  SAT_MIN = {{3{1'b1}}, {(SAMPLE_W-1){1'b0}}};

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      note_idx_q, note_idx_d;
    logic [SC_W-1:0]       samp_q, samp_d;
    logic [SAMPLE_W-1:0]   data_q, data_d;

    logic                  start;
    logic                  issue;
    logic                  last_note;
    logic                  clear_voices;
    logic                  load;
    logic [VOICES-1:0][MIX_W-1:0] contrib;
    logic signed [MIX_W-1:0]      mix_sum;
    logic [SAMPLE_W-1:0]          mix_sat;

    assign start = write_en && (note_count != '0);
    assign issue = (state_q == ST_PLAY) && write_ready;
    // A shrunken note_count (note_idx already past it) ends the tune; the
    // DEPTH-1 clamp keeps the table lookup inside note_mem.
    assign last_note = (int'(note_idx_q) + 1 >= int'(note_count))
                    || (note_idx_q == IDX_W'(DEPTH - 1));
    assign clear_voices = ((state_q == ST_IDLE) && start) || (issue && (samp_q == SC_LAST));
    assign load = ((state_q == ST_IDLE) && start) || issue;

    always_comb begin
        state_d    = state_q;
        note_idx_d = note_idx_q;
        samp_d     = samp_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_PLAY;
                    note_idx_d = '0;
                    samp_d     = '0;
                end
            end
            ST_PLAY: begin
                if (!write_en) begin
                    state_d = ST_IDLE;
                end else if (issue) begin
                    if (samp_q == SC_LAST) begin
                        samp_d = '0;
                        if (!last_note) begin
                            note_idx_d = note_idx_q + IDX_W'(1);
                        end else begin
                            note_idx_d = '0;
                            if (!loop_en) begin
                                state_d = ST_DONE;
                            end
                        end
                    end else begin
                        samp_d = samp_q + SC_W'(1);
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Each voice advances its phase on the current note and contributes the
    // level it will have for the *next* sample, so write_data is registered
    // one issue ahead and is always the sample currently being offered.
    for (genvar v = 0; v < VOICES; v++) begin : g_voice
        logic [NOTE_W-1:0] cur_note;
        logic [NOTE_W-1:0] nxt_note;
        logic [HALF_W-1:0] half;
        logic [HALF_W-1:0] phase_q, phase_d;
        logic              pol_q, pol_d;    // 1 = negative half-cycle

        assign cur_note = note_mem[(v*DEPTH + int'(note_idx_q))*NOTE_W +: NOTE_W];
        assign nxt_note = note_mem[(v*DEPTH + int'(note_idx_d))*NOTE_W +: NOTE_W];

        note_period_rom #(.NOTE_W(NOTE_W)) u_rom (
            .note_i (cur_note),
            .half_o (half)
        );

        always_comb begin
            phase_d = phase_q;
            pol_d   = pol_q;
            if (clear_voices) begin
                phase_d = '0;
                pol_d   = 1'b0;
            end else if (issue && (cur_note != '0)) begin
                if (phase_q == half - HALF_W'(1)) begin
                    phase_d = '0;
                    pol_d   = ~pol_q;
                end else begin
                    phase_d = phase_q + HALF_W'(1);
                end
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                phase_q <= '0;
                pol_q   <= 1'b0;
            end else begin
                phase_q <= phase_d;
                pol_q   <= pol_d;
            end
        end

        assign contrib[v] = (nxt_note == '0) ? '0 : (pol_d ? AMP_NEG : AMP_POS);
    end

    always_comb begin
        mix_sum = '0;
        for (int v = 0; v < VOICES; v++) begin
            mix_sum = mix_sum + $signed(contrib[v]);
        end
        if (mix_sum > SAT_MAX) begin
            mix_sat = SAT_MAX[SAMPLE_W-1:0];
        end else if (mix_sum < SAT_MIN) begin
            mix_sat = SAT_MIN[SAMPLE_W-1:0];
        end else begin
            mix_sat = mix_sum[SAMPLE_W-1:0];
        end
        data_d = load ? mix_sat : data_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            note_idx_q <= '0;
            samp_q     <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            note_idx_q <= note_idx_d;
            samp_q     <= samp_d;
            data_q     <= data_d;
        end
    end

    assign write      = issue;
    assign write_data = data_q;
    assign busy       = (state_q == ST_PLAY);
    assign done       = (state_q == ST_DONE);
    assign note_idx   = note_idx_q;

endmodule
